// File: rtl/da_operand_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// da_operand_loader: ping-pong loader packing an 8-bit byte stream into 3x3 matrix
// plus coefficient frames for the DA multiplier. Optional macro: LOADER_COEF_REUSE_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
module da_operand_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d,
  output logic [7:0] e,
  output logic [7:0] f,
  output logic [7:0] g,
  output logic [7:0] h,
  output logic [7:0] j,
  output logic [7:0] c0,
  output logic [7:0] c1,
  output logic [7:0] c2,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int         NSLOT      = 12;
  localparam logic [3:0] LAST_SLOT  = 4'd11;
  localparam logic [3:0] SHORT_SLOT = 4'd8;

  logic [7:0] bank_q [2][NSLOT];
  logic [7:0] bank_d [2][NSLOT];
  logic [1:0] full_q, full_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic accept;
  logic release_frame;
  logic short_done;
  logic frame_done;

  assign in_ready      = ~full_q[wr_ptr_q];
  assign out_valid     = full_q[rd_ptr_q];
  assign accept        = in_valid & in_ready;
  assign release_frame = out_valid & out_ready;

`ifdef LOADER_COEF_REUSE_EN
  logic [7:0] coef_q [3];
  logic [7:0] coef_d [3];

  assign short_done = (cnt_q == SHORT_SLOT) & in_last;
`else
  logic unused_in_last;

  assign unused_in_last = in_last;
  assign short_done     = 1'b0;
`endif

  assign frame_done = (cnt_q == LAST_SLOT) | short_done;

  always_comb begin
    bank_d   = bank_q;
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
`ifdef LOADER_COEF_REUSE_EN
    coef_d   = coef_q;
`endif

    // Completion and release always target different banks, so both may apply.
    if (release_frame) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end

    if (accept) begin
      bank_d[wr_ptr_q][cnt_q] = in_data;
`ifdef LOADER_COEF_REUSE_EN
      if (short_done) begin
        bank_d[wr_ptr_q][9]  = coef_q[0];
        bank_d[wr_ptr_q][10] = coef_q[1];
        bank_d[wr_ptr_q][11] = coef_q[2];
      end
      if (cnt_q == LAST_SLOT) begin
        coef_d[0] = bank_q[wr_ptr_q][9];
        coef_d[1] = bank_q[wr_ptr_q][10];
        coef_d[2] = in_data;
      end
`endif
      if (frame_done) begin
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
        cnt_d            = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < NSLOT; k++) begin
          bank_q[i][k] <= 8'd0;
        end
      end
      full_q   <= 2'b00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      bank_q   <= bank_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef LOADER_COEF_REUSE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        coef_q[k] <= 8'd0;
      end
    end else begin
      coef_q <= coef_d;
    end
  end
`endif

  assign a  = bank_q[rd_ptr_q][0];
  assign b  = bank_q[rd_ptr_q][1];
  assign c  = bank_q[rd_ptr_q][2];
  assign d  = bank_q[rd_ptr_q][3];
  assign e  = bank_q[rd_ptr_q][4];
  assign f  = bank_q[rd_ptr_q][5];
  assign g  = bank_q[rd_ptr_q][6];
  assign h  = bank_q[rd_ptr_q][7];
  assign j  = bank_q[rd_ptr_q][8];
  assign c0 = bank_q[rd_ptr_q][9];
  assign c1 = bank_q[rd_ptr_q][10];
  assign c2 = bank_q[rd_ptr_q][11];

endmodule
`default_nettype wire

// File: tb/tb_da_operand_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_da_operand_loader: directed self-checking bench for da_operand_loader.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_da_operand_loader;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic [7:0] a, b, c, d, e, f, g, h, j, c0, c1, c2;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int passes = 0;

  da_operand_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .e        (e),
    .f        (f),
    .g        (g),
    .h        (h),
    .j        (j),
    .c0       (c0),
    .c1       (c1),
    .c2       (c2),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Called at a negedge; presents one byte for one cycle and returns at the next negedge.
  task automatic send(input logic [7:0] val, input logic last);
    in_valid = 1'b1;
    in_data  = val;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'hEE;
  endtask

  task automatic release_one();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passes++;
    checks++; if ({a, j, c0, c2} !== 32'd0) $display("FAIL reset_outputs got %h want 0", {a, j, c0, c2}); else passes++;
  endtask

  task automatic test_basic();
    int ready_drops = 0;
    for (int k = 1; k <= 12; k++) begin
      if (in_ready !== 1'b1) ready_drops++;
      if (k == 12) begin
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %0b want 0", out_valid); else passes++;
      end
      send(8'(k), 1'b0);
    end
    checks++; if (ready_drops != 0) $display("FAIL basic_in_ready_drops got %0d want 0", ready_drops); else passes++;
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid got %0b want 1", out_valid); else passes++;
    checks++; if ({a, j, c0, c2} !== {8'd1, 8'd9, 8'd10, 8'd12})
      $display("FAIL basic_frame got a=%0d j=%0d c0=%0d c2=%0d want 1 9 10 12", a, j, c0, c2); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready_after got %0b want 1", in_ready); else passes++;
  endtask

  task automatic test_both_full();
    for (int k = 21; k <= 32; k++) send(8'(k), 1'b0);
    checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %0b want 0", in_ready); else passes++;
    checks++; if ({out_valid, a, c2} !== {1'b1, 8'd1, 8'd12})
      $display("FAIL full_hold got v=%0b a=%0d c2=%0d want 1 1 12", out_valid, a, c2); else passes++;
    // Bytes offered while both banks are full must be dropped.
    in_valid = 1'b1;
    in_data  = 8'h99;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({in_ready, a, c2} !== {1'b0, 8'd1, 8'd12})
      $display("FAIL full_ignore got rdy=%0b a=%0d c2=%0d want 0 1 12", in_ready, a, c2); else passes++;
    release_one();
    checks++; if ({out_valid, a, c2} !== {1'b1, 8'd21, 8'd32})
      $display("FAIL full_release got v=%0b a=%0d c2=%0d want 1 21 32", out_valid, a, c2); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL full_release_ready got %0b want 1", in_ready); else passes++;
  endtask

  task automatic test_back_to_back();
    for (int k = 70; k <= 80; k++) send(8'(k), 1'b0);
    checks++; if ({out_valid, a} !== {1'b1, 8'd21})
      $display("FAIL b2b_before got v=%0b a=%0d want 1 21", out_valid, a); else passes++;
    out_ready = 1'b1;
    send(8'd81, 1'b0);
    out_ready = 1'b0;
    checks++; if ({out_valid, a, b, c2} !== {1'b1, 8'd70, 8'd71, 8'd81})
      $display("FAIL b2b_switch got v=%0b a=%0d b=%0d c2=%0d want 1 70 71 81", out_valid, a, b, c2); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got %0b want 1", in_ready); else passes++;
    release_one();
    checks++; if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL b2b_drain got v=%0b rdy=%0b want 0 1", out_valid, in_ready); else passes++;
  endtask

  task automatic test_mid_reset();
    for (int k = 90; k <= 94; k++) send(8'(k), 1'b0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checks++; if ({out_valid, in_ready, a} !== {1'b0, 1'b1, 8'd0})
      $display("FAIL mreset_state got v=%0b rdy=%0b a=%0d want 0 1 0", out_valid, in_ready, a); else passes++;
    for (int k = 40; k <= 51; k++) send(8'(k), 1'b0);
    checks++; if ({out_valid, a, b, e, j, c0, c2} !== {1'b1, 8'd40, 8'd41, 8'd44, 8'd48, 8'd49, 8'd51})
      $display("FAIL mreset_frame got v=%0b a=%0d b=%0d e=%0d j=%0d c0=%0d c2=%0d want 1 40 41 44 48 49 51",
               out_valid, a, b, e, j, c0, c2); else passes++;
    release_one();
  endtask

  task automatic test_gaps();
    for (int k = 100; k <= 111; k++) begin
      if (k == 111) begin
        checks++; if (out_valid !== 1'b0) $display("FAIL gaps_early_valid got %0b want 0", out_valid); else passes++;
      end
      send(8'(k), 1'b0);
      if (k != 111) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    checks++; if ({out_valid, a, c, h, j, c1, c2} !== {1'b1, 8'd100, 8'd102, 8'd107, 8'd108, 8'd110, 8'd111})
      $display("FAIL gaps_frame got v=%0b a=%0d c=%0d h=%0d j=%0d c1=%0d c2=%0d want 1 100 102 107 108 110 111",
               out_valid, a, c, h, j, c1, c2); else passes++;
    release_one();
  endtask

  task automatic test_in_last();
    // in_last on the byte at cnt=3 is never a frame end.
    for (int k = 1; k <= 12; k++) send(8'(k), k == 4);
    checks++; if ({out_valid, a, d, e, c2} !== {1'b1, 8'd1, 8'd4, 8'd5, 8'd12})
      $display("FAIL last_mid got v=%0b a=%0d d=%0d e=%0d c2=%0d want 1 1 4 5 12", out_valid, a, d, e, c2); else passes++;
    release_one();
    for (int k = 60; k <= 68; k++) send(8'(k), k == 68);
`ifdef LOADER_COEF_REUSE_EN
    checks++; if ({out_valid, a, j, c0, c1, c2} !== {1'b1, 8'd60, 8'd68, 8'd10, 8'd11, 8'd12})
      $display("FAIL last_short got v=%0b a=%0d j=%0d c0=%0d c1=%0d c2=%0d want 1 60 68 10 11 12",
               out_valid, a, j, c0, c1, c2); else passes++;
`else
    checks++; if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL last_ignored got v=%0b rdy=%0b want 0 1", out_valid, in_ready); else passes++;
    for (int k = 69; k <= 71; k++) send(8'(k), 1'b0);
    checks++; if ({out_valid, a, j, c0, c2} !== {1'b1, 8'd60, 8'd68, 8'd69, 8'd71})
      $display("FAIL last_full got v=%0b a=%0d j=%0d c0=%0d c2=%0d want 1 60 68 69 71",
               out_valid, a, j, c0, c2); else passes++;
`endif
    release_one();
  endtask

  initial begin
    reset     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_both_full();
    test_back_to_back();
    test_mid_reset();
    test_gaps();
    test_in_last();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
